sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Selects one request per cycle and forwards it to the memory side.
- Records which requester owns each outstanding transaction, and routes each in-order data_ok/rdata back to that requester.
- Sits between the pipeline stages and the external memory bridge.

Parameters:
- OUTSTANDING, 2, maximum accepted-but-unanswered transactions (power of 2, 1..4).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req / i_wr  in  1 / 1  inst request valid; write flag (the IF stage always drives 0)
- i_size  in  2  0=byte, 1=half, 2=word
- i_addr / i_wdata  in  32 / 32  inst address and write data
- i_wstrb  in  4  inst byte enables
- i_addr_ok / i_data_ok  out  1 / 1  inst request accepted; inst response valid
- i_rdata  out  32  inst read data
- d_req, d_wr, d_size, d_addr, d_wstrb, d_wdata, d_addr_ok, d_data_ok, d_rdata: same as the i_* set, for the data requester
- m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata  out  memory-side request (widths as the i_* set)
- m_addr_ok / m_data_ok  in  1 / 1  memory accepts request; memory response valid
- m_rdata  in  32  memory read data

Behaviour:
- Handshakes:
  - A request transfers on the cycle req & addr_ok are both high.
  - A response transfers on the cycle data_ok is high. It is single-cycle; requesters always accept it.
  - Memory returns responses in acceptance order.
- Grant FSM with states IDLE, GNT_I, GNT_D:
  - IDLE: if d_req, go to GNT_D and drive data fields combinationally this cycle; else if i_req, go to GNT_I. Data has fixed priority.
  - GNT_x: the grant is held until m_req & m_addr_ok, then return to IDLE.
  - A grant never switches while a request is pending unaccepted, so m_addr/m_wdata stay stable.
  - The granted requester must keep req high until addr_ok; the arbiter does not need to support withdrawal.
- Mux:
  - m_* = fields of the granted requester.
  - m_req = granted req & ~fifo_full.
  - x_addr_ok = m_addr_ok & m_req & (grant==x).
  - Non-granted addr_ok = 0.
- Ownership FIFO:
  - OUTSTANDING entries, 1-bit owner ID (0=inst, 1=data).
  - Push on memory address handshake; pop on m_data_ok.
  - Push and pop in the same cycle is allowed, with the count unchanged.
  - Full: m_req forced 0, and the grant is held.
  - m_data_ok while the FIFO is empty is a protocol error: ignore it and drive no x_data_ok.
- Response route:
  - i_data_ok = m_data_ok & ~head_owner; d_data_ok = m_data_ok & head_owner.
  - i_rdata = d_rdata = m_rdata (unqualified).
- Latency: zero added cycles on both request and response paths (combinational pass-through).
- Reset:
  - FSM=IDLE, FIFO empty, pointers 0.
  - All outputs 0: m_req, addr_ok, data_ok.
  - Reset mid-transaction drops all outstanding ownership. The memory side is reset by the same signal.
- Pointer wrap-around uses log2(OUTSTANDING)-bit pointers plus a count register of log2(OUTSTANDING)+1 bits.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: IDLE arbitration alternates priority.
  - A 1-bit last_grant register, reset to inst, is updated on each memory address handshake.
  - When both req are high, the requester not equal to last_grant wins.
- Undefined: fixed data-over-inst priority; last_grant register absent.

Decomposition:
- Shared header macro.vh gains ARB_OWNER_INST=1'b0, ARB_OWNER_DATA=1'b1, grant-state encodings (IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2), and ARB_REQ_BUS_LEN (= 1+2+32+4+32 = 71) for packed request buses.
- One natural sub-module: arb_owner_fifo, a parameterized depth-N, 1-bit-wide synchronous FIFO with push/pop/full/empty/head.

Test Plan:
- Single inst read: i_req=1, i_addr=0x1c000000, m_addr_ok=1 same cycle, m_data_ok 2 cycles later with rdata=0x02800c06 -> m_addr=0x1c000000, i_addr_ok=1 in cycle 0, i_data_ok=1 with i_rdata=0x02800c06, d_data_ok=0.
- Simultaneous requests: i_req=d_req=1, d_addr=0x1c010000 -> d granted first. Next cycle i is granted (i_req still high). Responses R1,R2 route to d then i. Under ARB_ROUND_ROBIN_EN with last_grant=data, i wins first.
- Backpressure hold: d_req=1, m_addr_ok=0 for 3 cycles, i_req asserted at cycle 1 -> m_addr stays d_addr all 4 cycles; i_addr_ok=0 until the d handshake.
- FIFO full: OUTSTANDING=2, two accepted requests with no m_data_ok -> third request sees m_req=0 and addr_ok=0. A single m_data_ok pops one entry, and the third is accepted the next cycle.
- Same-cycle push/pop: FIFO count=1 (owner inst), new d handshake and m_data_ok in the same cycle -> i_data_ok=1, count remains 1, head=data.
- Reset mid-operation: reset asserted with 2 outstanding -> next cycle m_req=0, FIFO empty; a spurious m_data_ok produces no i_data_ok/d_data_ok.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared owner IDs, grant-state encoding and sizing helpers for the SRAM arbiter.
package sram_arbiter_pkg;

    localparam logic ARB_OWNER_INST = 1'b0;
    localparam logic ARB_OWNER_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } grant_e;

    // Packed request bus: {wr, size, addr, wstrb, wdata}; 71 bits for 32-bit address/data.
    function automatic int req_bus_len(input int addr_w, input int data_w);
        return 1 + 2 + addr_w + data_w / 8 + data_w;
    endfunction

    // Pointer width that stays legal for a single-entry FIFO.
    function automatic int ptr_w(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_arbiter_owner_fifo.sv
// arb_owner_fifo: depth-N, 1-bit-wide synchronous FIFO recording the owner of each outstanding transaction.
//   clk, reset  : clock, synchronous active-high reset (empties the FIFO)
//   push, din   : enqueue owner ID (ignored when full)
//   pop         : dequeue the head entry (ignored when empty)
//   full, empty : occupancy flags
//   head        : owner ID at the read pointer
import sram_arbiter_pkg::*;

module arb_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CAP = CW'(DEPTH);

    logic mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic do_push, do_pop;

    always_comb begin
        full    = count == CAP;
        empty   = count == '0;
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
            // Simultaneous push and pop leaves the count unchanged.
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-like memory port between the IF (inst) and MEM (data) requesters.
//   clk, reset                 : clock, synchronous active-high reset
//   i_* / d_* request inputs   : req, wr, size, addr, wstrb, wdata of each requester
//   i_addr_ok / d_addr_ok      : request accepted (zero-latency pass-through of m_addr_ok)
//   i_data_ok / d_data_ok      : response valid, routed by the recorded owner of the oldest transaction
//   i_rdata / d_rdata          : memory read data, passed through unqualified
//   m_* request outputs        : fields of the granted requester
//   m_addr_ok, m_data_ok, m_rdata : memory-side handshakes and read data
// Build option: define ARB_ROUND_ROBIN_EN to alternate priority between requesters
// (default: data always wins over inst).
import sram_arbiter_pkg::*;

module sram_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic                i_wr,
    input  logic [1:0]          i_size,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W/8-1:0] i_wstrb,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic                i_addr_ok,
    output logic                i_data_ok,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_wr,
    input  logic [1:0]          d_size,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_addr_ok,
    output logic                d_data_ok,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    output logic                m_wr,
    output logic [1:0]          m_size,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int REQ_W = req_bus_len(ADDR_W, DATA_W);

    grant_e state;
    logic pick_d, grant_i, grant_d, hs, pop, full, empty, head;
    logic [REQ_W-1:0] i_bus, d_bus, m_bus;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;

    always_ff @(posedge clk) begin
        if (reset) last_grant <= ARB_OWNER_INST;
        else if (hs) last_grant <= grant_d;
    end

    // On a tie the requester that was not served last wins.
    assign pick_d = d_req & (~i_req | (last_grant == ARB_OWNER_INST));
`else
    assign pick_d = d_req;
`endif

    // In IDLE the grant is decided combinationally so a request can be forwarded in its first cycle.
    always_comb begin
        grant_d   = (state == GNT_D) | ((state == IDLE) & pick_d);
        grant_i   = (state == GNT_I) | ((state == IDLE) & ~pick_d & i_req);
        i_bus     = {i_wr, i_size, i_addr, i_wstrb, i_wdata};
        d_bus     = {d_wr, d_size, d_addr, d_wstrb, d_wdata};
        m_bus     = grant_d ? d_bus : i_bus;
        m_req     = ~reset & ~full & (grant_d ? d_req : grant_i & i_req);
        hs        = m_req & m_addr_ok;
        i_addr_ok = hs & grant_i;
        d_addr_ok = hs & grant_d;
        // A response with nothing outstanding is a protocol error and is dropped.
        pop       = ~reset & m_data_ok & ~empty;
        i_data_ok = pop & (head == ARB_OWNER_INST);
        d_data_ok = pop & (head == ARB_OWNER_DATA);
    end

    assign {m_wr, m_size, m_addr, m_wstrb, m_wdata} = m_bus;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    // The grant is held until the memory handshake, keeping m_* stable under backpressure or a full FIFO.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= hs ? IDLE : grant_d ? GNT_D : grant_i ? GNT_I : IDLE;
    end

    arb_owner_fifo #(
        .DEPTH(OUTSTANDING)
    ) u_owner_fifo (
        .clk  (clk),
        .reset(reset),
        .push (hs),
        .din  (grant_d),
        .pop  (pop),
        .full (full),
        .empty(empty),
        .head (head)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_sram_arbiter;

    localparam int N = 2;

    logic clk = 1'b0;
    logic reset;
    logic i_req, i_wr, d_req, d_wr, m_req, m_wr;
    logic [1:0] i_size, d_size, m_size;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata, m_addr, m_wdata;
    logic [3:0] i_wstrb, d_wstrb, m_wstrb;
    logic i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_rdata, d_rdata, m_rdata;
    logic m_addr_ok, m_data_ok;
    logic [4:0] st;
    logic [70:0] m_bus;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign st = {m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok};
    assign m_bus = {m_wr, m_size, m_addr, m_wstrb, m_wdata};

    sram_arbiter #(.OUTSTANDING(N), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wstrb(i_wstrb), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    task automatic idle();
        i_req = 0; i_wr = 0; i_size = 2'd2; i_addr = 0; i_wstrb = 0; i_wdata = 0;
        d_req = 0; d_wr = 0; d_size = 2'd2; d_addr = 0; d_wstrb = 0; d_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1; i_req = 1; d_req = 1; m_addr_ok = 1; m_data_ok = 1;
        @(negedge clk);
        n_cmp++; if (st !== 5'b00000) begin n_err++; $display("FAIL reset_hold: status=%b want %b", st, 5'b00000); end
        tick(); tick();
        reset = 0; idle();
        @(negedge clk);
        n_cmp++; if (st !== 5'b00000) begin n_err++; $display("FAIL reset_idle: status=%b want %b", st, 5'b00000); end
        tick();
    endtask

    task automatic test_single_read();
        i_req = 1; i_addr = 32'h1c000000; m_addr_ok = 1;
        @(negedge clk);
        n_cmp++; if (st !== 5'b11000) begin n_err++; $display("FAIL single_req: status=%b want %b", st, 5'b11000); end
        n_cmp++; if (m_addr !== 32'h1c000000) begin n_err++; $display("FAIL single_addr: m_addr=%h want %h", m_addr, 32'h1c000000); end
        tick();
        idle();
        tick();
        m_data_ok = 1; m_rdata = 32'h02800c06;
        @(negedge clk);
        n_cmp++; if (st !== 5'b00010) begin n_err++; $display("FAIL single_resp: status=%b want %b", st, 5'b00010); end
        n_cmp++; if (i_rdata !== 32'h02800c06) begin n_err++; $display("FAIL single_rdata: i_rdata=%h want %h", i_rdata, 32'h02800c06); end
        tick();
        idle();
    endtask

    task automatic test_simultaneous();
        logic [31:0] ia, r1, r2;
        ia = $urandom; r1 = $urandom; r2 = $urandom;
        i_req = 1; i_addr = ia; d_req = 1; d_addr = 32'h1c010000; m_addr_ok = 1;
        @(negedge clk);
        n_cmp++; if (st !== 5'b10100 || m_addr !== 32'h1c010000) begin n_err++; $display("FAIL simul_first: status=%b addr=%h want %b %h", st, m_addr, 5'b10100, 32'h1c010000); end
        tick();
        d_req = 0;
        @(negedge clk);
        n_cmp++; if (st !== 5'b11000 || m_addr !== ia) begin n_err++; $display("FAIL simul_second: status=%b addr=%h want %b %h", st, m_addr, 5'b11000, ia); end
        tick();
        idle();
        m_data_ok = 1; m_rdata = r1;
        @(negedge clk);
        n_cmp++; if (st !== 5'b00001 || d_rdata !== r1) begin n_err++; $display("FAIL simul_r1: status=%b rdata=%h want %b %h", st, d_rdata, 5'b00001, r1); end
        tick();
        m_rdata = r2;
        @(negedge clk);
        n_cmp++; if (st !== 5'b00010 || i_rdata !== r2) begin n_err++; $display("FAIL simul_r2: status=%b rdata=%h want %b %h", st, i_rdata, 5'b00010, r2); end
        tick();
        idle();
    endtask

    task automatic test_backpressure();
        logic [31:0] da, ia;
        da = 32'h1c020040; ia = $urandom;
        d_req = 1; d_addr = da; d_wr = 1; d_wdata = $urandom; d_wstrb = 4'hf;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin i_req = 1; i_addr = ia; end
            m_addr_ok = (c == 3);
            @(negedge clk);
            n_cmp++; if (m_addr !== da || st !== (c == 3 ? 5'b10100 : 5'b10000)) begin n_err++; $display("FAIL backpressure_c%0d: status=%b addr=%h want %b %h", c, st, m_addr, (c == 3 ? 5'b10100 : 5'b10000), da); end
            tick();
        end
        d_req = 0;
        @(negedge clk);
        n_cmp++; if (st !== 5'b11000 || m_addr !== ia) begin n_err++; $display("FAIL backpressure_inst: status=%b addr=%h want %b %h", st, m_addr, 5'b11000, ia); end
        tick();
        idle();
        m_data_ok = 1;
        @(negedge clk);
        n_cmp++; if (st !== 5'b00001) begin n_err++; $display("FAIL backpressure_r1: status=%b want %b", st, 5'b00001); end
        tick();
        @(negedge clk);
        n_cmp++; if (st !== 5'b00010) begin n_err++; $display("FAIL backpressure_r2: status=%b want %b", st, 5'b00010); end
        tick();
        idle();
    endtask

    task automatic test_fifo_full();
        logic [31:0] ib;
        ib = $urandom;
        d_req = 1; d_addr = 32'h00001000; m_addr_ok = 1;
        @(negedge clk);
        n_cmp++; if (st !== 5'b10100) begin n_err++; $display("FAIL full_acc1: status=%b want %b", st, 5'b10100); end
        tick();
        d_addr = 32'h00001004;
        @(negedge clk);
        n_cmp++; if (st !== 5'b10100) begin n_err++; $display("FAIL full_acc2: status=%b want %b", st, 5'b10100); end
        tick();
        d_req = 0; i_req = 1; i_addr = ib;
        @(negedge clk);
        n_cmp++; if (st !== 5'b00000) begin n_err++; $display("FAIL full_block: status=%b want %b", st, 5'b00000); end
        tick();
        m_data_ok = 1;
        @(negedge clk);
        n_cmp++; if (st !== 5'b00001) begin n_err++; $display("FAIL full_pop: status=%b want %b", st, 5'b00001); end
        tick();
        m_data_ok = 0;
        @(negedge clk);
        n_cmp++; if (st !== 5'b11000 || m_addr !== ib) begin n_err++; $display("FAIL full_retry: status=%b addr=%h want %b %h", st, m_addr, 5'b11000, ib); end
        tick();
        idle();
        m_data_ok = 1;
        @(negedge clk);
        n_cmp++; if (st !== 5'b00001) begin n_err++; $display("FAIL full_drain1: status=%b want %b", st, 5'b00001); end
        tick();
        @(negedge clk);
        n_cmp++; if (st !== 5'b00010) begin n_err++; $display("FAIL full_drain2: status=%b want %b", st, 5'b00010); end
        tick();
        idle();
    endtask

    task automatic test_push_pop();
        i_req = 1; i_addr = $urandom; m_addr_ok = 1;
        @(negedge clk);
        n_cmp++; if (st !== 5'b11000) begin n_err++; $display("FAIL pushpop_first: status=%b want %b", st, 5'b11000); end
        tick();
        i_req = 0; d_req = 1; d_addr = $urandom; m_data_ok = 1;
        @(negedge clk);
        n_cmp++; if (st !== 5'b10110) begin n_err++; $display("FAIL pushpop_same: status=%b want %b", st, 5'b10110); end
        tick();
        d_req = 0; m_addr_ok = 0;
        @(negedge clk);
        n_cmp++; if (st !== 5'b00001) begin n_err++; $display("FAIL pushpop_head: status=%b want %b", st, 5'b00001); end
        tick();
        @(negedge clk);
        n_cmp++; if (st !== 5'b00000) begin n_err++; $display("FAIL pushpop_spurious: status=%b want %b", st, 5'b00000); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_addr = $urandom; m_addr_ok = 1;
        @(negedge clk);
        n_cmp++; if (st !== 5'b10100) begin n_err++; $display("FAIL rstmid_d: status=%b want %b", st, 5'b10100); end
        tick();
        d_req = 0; i_req = 1; i_addr = $urandom;
        @(negedge clk);
        n_cmp++; if (st !== 5'b11000) begin n_err++; $display("FAIL rstmid_i: status=%b want %b", st, 5'b11000); end
        tick();
        reset = 1; i_req = 0; d_req = 1;
        @(negedge clk);
        n_cmp++; if (st !== 5'b00000) begin n_err++; $display("FAIL rstmid_during: status=%b want %b", st, 5'b00000); end
        tick();
        reset = 0; idle(); m_data_ok = 1;
        @(negedge clk);
        n_cmp++; if (st !== 5'b00000) begin n_err++; $display("FAIL rstmid_spurious: status=%b want %b", st, 5'b00000); end
        tick();
        idle(); i_req = 1; i_addr = $urandom; m_addr_ok = 1;
        @(negedge clk);
        n_cmp++; if (st !== 5'b11000) begin n_err++; $display("FAIL rstmid_new: status=%b want %b", st, 5'b11000); end
        tick();
        idle(); m_data_ok = 1;
        @(negedge clk);
        n_cmp++; if (st !== 5'b00010) begin n_err++; $display("FAIL rstmid_route: status=%b want %b", st, 5'b00010); end
        tick();
        idle();
    endtask

    // Reference model: a requester that has been offered the port keeps it until accepted;
    // owners of accepted requests queue up and are answered strictly in order.
    task automatic test_random();
        int owner_q[$];
        int held, last, win;
        bit i_pend, d_pend, full, e_mreq, e_hs, e_pop;
        logic [4:0] e_st;
        logic [70:0] e_bus;
        held = -1; last = 0; i_pend = 0; d_pend = 0;
        idle(); reset = 1; tick(); reset = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; i_addr = $urandom; i_size = 2'($urandom_range(0, 2));
                i_wstrb = 4'($urandom); i_wdata = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_addr = $urandom; d_size = 2'($urandom_range(0, 2));
                d_wr = 1'($urandom); d_wstrb = 4'($urandom); d_wdata = $urandom;
            end
            i_req = i_pend; d_req = d_pend;
            m_addr_ok = $urandom_range(0, 9) < 6;
            m_data_ok = owner_q.size() > 0 ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
            m_rdata = $urandom;
            win = held;
            if (win < 0 && i_pend && d_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
                win = last == 1 ? 0 : 1;
`else
                win = 1;
`endif
            end else if (win < 0) begin
                win = d_pend ? 1 : i_pend ? 0 : -1;
            end
            full = owner_q.size() == N;
            e_mreq = win >= 0 && !full;
            e_hs = e_mreq && m_addr_ok;
            e_pop = m_data_ok && owner_q.size() > 0;
            e_st = {e_mreq, e_hs && win == 0, e_hs && win == 1, e_pop && owner_q[0] == 0, e_pop && owner_q[0] == 1};
            e_bus = win == 1 ? {d_wr, d_size, d_addr, d_wstrb, d_wdata} : {i_wr, i_size, i_addr, i_wstrb, i_wdata};
            @(negedge clk);
            n_cmp++; if (st !== e_st) begin n_err++; $display("FAIL random_status cyc=%0d: status=%b want %b", cyc, st, e_st); end
            if (e_mreq) begin
                n_cmp++; if (m_bus !== e_bus) begin n_err++; $display("FAIL random_bus cyc=%0d: bus=%h want %h", cyc, m_bus, e_bus); end
            end
            if (e_pop) begin
                n_cmp++; if ((owner_q[0] == 0 ? i_rdata : d_rdata) !== m_rdata) begin n_err++; $display("FAIL random_rdata cyc=%0d: rdata=%h want %h", cyc, (owner_q[0] == 0 ? i_rdata : d_rdata), m_rdata); end
            end
            if (e_pop) void'(owner_q.pop_front());
            if (e_hs) begin
                owner_q.push_back(win);
                last = win;
                if (win == 0) i_pend = 0; else d_pend = 0;
                held = -1;
            end else begin
                held = win;
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_backpressure();
        test_fifo_full();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
